dual_port_sram_be: RTL and testbench

Parametrised simple dual-port SRAM: one write port and one read port sharing `clk`. It succeeds the single-port tri-state SRAM. Adds:
- independent read/write addressing;
- per-byte write enables;
- selectable read latency;
- defined read-during-write behaviour;
- optional hardware clear of the array after reset.

It sits in the same memory library and is used as a buffer/register-file macro behind FIFOs and caches.

---
 rtl/dual_port_sram_be_if.sv | 29 ++
 rtl/dual_port_sram_be.sv | 134 +++++++++++++
 tb/tb_dual_port_sram_be.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_port_sram_be_if.sv
// Bus bundle for dual_port_sram_be: write port, read port and init status.
// master drives requests; slave (the SRAM) returns rd_data/rd_valid/init_done.
interface dual_port_sram_be_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_BYTES  = 4
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WIDTH-1:0]      wr_data;
   logic [NUM_BYTES-1:0]  wr_byte_en;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WIDTH-1:0]      rd_data;
   logic                  rd_valid;
   logic                  init_done;

   modport master (
      output wr_en, wr_addr, wr_data, wr_byte_en,
      output rd_en, rd_addr,
      input  rd_data, rd_valid, init_done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_byte_en,
      input  rd_en, rd_addr,
      output rd_data, rd_valid, init_done
   );
endinterface

// File: rtl/dual_port_sram_be.sv
// Simple dual-port SRAM: byte-enabled write port, 1/2-cycle read port,
// selectable collision policy, optional post-reset clear. Ports: clk, rst_n, bus.
module dual_port_sram_be #(
   parameter int WIDTH          = 32,
   parameter int DEPTH          = 16,
   parameter int ADDR_WIDTH     = $clog2(DEPTH),
   parameter int BYTE_WIDTH     = 8,
   parameter int READ_LATENCY   = 1,
   parameter bit WRITE_FIRST    = 1'b0,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   dual_port_sram_be_if.slave bus
);
   localparam int NUM_BYTES = WIDTH / BYTE_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
   logic                  clr_we;

   logic [WIDTH-1:0]      mem [DEPTH];

   logic                  init_done;
   logic                  wr_ok, rd_ok, rd_in, collide;
   logic [WIDTH-1:0]      old_word, rd_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR_ON_RESET ? CLEAR : READY;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      unique case (state)
         CLEAR: begin
            clr_we  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nxt = READY;
               cnt_nxt   = '0;
            end
         end
         READY: ;
         default: state_nxt = CLEAR;
      endcase
   end

   assign init_done     = (state == READY);
   assign bus.init_done = init_done;

   assign wr_ok = init_done && bus.wr_en &&
                  ({1'b0, bus.wr_addr} < DEPTH_W);
   assign rd_ok = init_done && bus.rd_en;
   assign rd_in = ({1'b0, bus.rd_addr} < DEPTH_W);

   // Writes land via NBA, so a same-edge read of mem sees the old word.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.wr_byte_en[i])
               mem[bus.wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   assign old_word = rd_in ? mem[bus.rd_addr] : '0;
   assign collide  = WRITE_FIRST && wr_ok && rd_in &&
                     (bus.rd_addr == bus.wr_addr);

   // Write-first forwarding merges only the enabled lanes.
   always_comb begin
      rd_word = old_word;
      if (collide) begin
         for (int i = 0; i < NUM_BYTES; i++) begin
            if (bus.wr_byte_en[i])
               rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                  bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   logic             s1_v;
   logic [WIDTH-1:0] s1_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v <= 1'b0;
         s1_d <= '0;
      end else begin
         s1_v <= rd_ok;
         if (rd_ok)
            s1_d <= rd_word;
      end
   end

   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign bus.rd_valid = s1_v;
         assign bus.rd_data  = s1_d;
      end else begin : g_lat2
         logic             s2_v;
         logic [WIDTH-1:0] s2_d;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_v <= 1'b0;
               s2_d <= '0;
            end else begin
               s2_v <= s1_v;
               if (s1_v)
                  s2_d <= s1_d;
            end
         end

         assign bus.rd_valid = s2_v;
         assign bus.rd_data  = s2_d;
      end
   endgenerate
endmodule

// File: tb/tb_dual_port_sram_be.sv
// Randomised + directed bench for dual_port_sram_be: two instances
// (16 deep/lat1/old-data and 12 deep/lat2/new-data) against a behavioural model.
module tb_dual_port_sram_be;
   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_byte_en;
   logic        rd_en;
   logic [3:0]  rd_addr;

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   dual_port_sram_be_if #(.WIDTH(32), .ADDR_WIDTH(4), .NUM_BYTES(4)) ia ();
   dual_port_sram_be_if #(.WIDTH(32), .ADDR_WIDTH(4), .NUM_BYTES(4)) ib ();

   assign ia.wr_en = wr_en;       assign ib.wr_en = wr_en;
   assign ia.wr_addr = wr_addr;   assign ib.wr_addr = wr_addr;
   assign ia.wr_data = wr_data;   assign ib.wr_data = wr_data;
   assign ia.wr_byte_en = wr_byte_en;
   assign ib.wr_byte_en = wr_byte_en;
   assign ia.rd_en = rd_en;       assign ib.rd_en = rd_en;
   assign ia.rd_addr = rd_addr;   assign ib.rd_addr = rd_addr;

   dual_port_sram_be #(
      .WIDTH(32), .DEPTH(16), .BYTE_WIDTH(8),
      .READ_LATENCY(1), .WRITE_FIRST(1'b0), .CLEAR_ON_RESET(1'b1)
   ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));

   dual_port_sram_be #(
      .WIDTH(32), .DEPTH(12), .BYTE_WIDTH(8),
      .READ_LATENCY(2), .WRITE_FIRST(1'b1), .CLEAR_ON_RESET(1'b1)
   ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   logic [31:0] mm   [2][16];
   bit          minit[2];
   int          mcnt [2];
   bit          rv   [2][4];
   logic [31:0] rdr  [2][4];
   bit          ev   [2];
   logic [31:0] ed   [2];
   int          E = 8;

   function automatic int dep(int k);  return (k == 0) ? 16 : 12; endfunction
   function automatic int lat(int k);  return (k == 0) ? 1 : 2;   endfunction

   function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                         logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         minit[k] = 0;
         mcnt[k]  = 0;
         ev[k]    = 0;
         ed[k]    = 0;
         for (int j = 0; j < 4; j++) begin
            rv[k][j]  = 0;
            rdr[k][j] = 0;
         end
      end
   endtask

   task automatic model_step();
      bit          wok, rok, rdv;
      logic [31:0] rdd;
      int          p;
      if (!rst_n) return;
      E++;
      for (int k = 0; k < 2; k++) begin
         wok = minit[k] && wr_en && (int'(wr_addr) < dep(k));
         rok = minit[k] && rd_en;
         rdv = rok;
         rdd = 0;
         if (rok && int'(rd_addr) < dep(k)) begin
            rdd = mm[k][rd_addr];
            if (k == 1 && wok && wr_addr == rd_addr)
               rdd = merge(rdd, wr_data, wr_byte_en);
         end
         if (wok)
            mm[k][wr_addr] = merge(mm[k][wr_addr], wr_data, wr_byte_en);
         if (!minit[k]) begin
            mm[k][mcnt[k]] = 0;
            mcnt[k]++;
            if (mcnt[k] == dep(k)) minit[k] = 1;
         end
         rv[k][E % 4]  = rdv;
         rdr[k][E % 4] = rdd;
         p = (E - lat(k) + 1) % 4;
         ev[k] = rv[k][p];
         if (ev[k]) ed[k] = rdr[k][p];
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("a_valid", 32'(ia.rd_valid), 32'(ev[0]));
         chk("a_data", ia.rd_data, ed[0]);
         chk("a_init", 32'(ia.init_done), 32'(minit[0]));
         chk("b_valid", 32'(ib.rd_valid), 32'(ev[1]));
         chk("b_data", ib.rd_data, ed[1]);
         chk("b_init", 32'(ib.init_done), 32'(minit[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle();
      wr_en = 0; rd_en = 0;
   endtask

   task automatic do_reset(int n);
      rst_n = 0;
      model_reset();
      repeat (n) tick();
      rst_n = 1;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] w [16];
   int na, nb, cnt_v, first_v, last_v, idx, nz;

   initial begin
      rst_n = 1; wr_en = 0; rd_en = 0;
      wr_addr = 0; wr_data = 0; wr_byte_en = 0; rd_addr = 0;
      #2;
      rst_n = 0;
      model_reset();
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 16; j++) mm[k][j] = 32'hx;
      chk_on = 1;
      repeat (2) tick();
      rst_n = 1;
      repeat (20) tick();

      // seed mem[5], then reset: the clear must wipe it
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
      tick();
      idle();
      tick();
      do_reset(2);

      rd_en = 1; rd_addr = 5;
      na = 0; nb = 0; cnt_v = 0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (n <= 16 && ia.rd_valid) cnt_v++;
         if (ia.init_done && na == 0) na = n;
         if (ib.init_done && nb == 0) nb = n;
      end
      chk("a_clear_len", 32'(na), 32'd16);
      chk("b_clear_len", 32'(nb), 32'd12);
      chk("valid_in_clear", 32'(cnt_v), 32'd0);
      chk("a_seed_cleared", ia.rd_data, 32'h0);
      chk("b_seed_cleared", ib.rd_data, 32'h0);
      idle();
      tick(); tick();

      // byte-enable merge
      wr_en = 1; wr_addr = 3; wr_data = 32'h11223344; wr_byte_en = 4'b1111;
      tick();
      wr_data = 32'hAABBCCDD; wr_byte_en = 4'b0101;
      tick();
      wr_en = 0; rd_en = 1; rd_addr = 3;
      tick();
      rd_en = 0;
      chk("a_be_merge", ia.rd_data, 32'h11BB33DD);
      tick();
      chk("b_be_merge", ib.rd_data, 32'h11BB33DD);
      tick();

      // collision on address 7 (zero after clear)
      wr_en = 1; wr_addr = 7; wr_data = 32'hCAFEF00D; wr_byte_en = 4'hF;
      rd_en = 1; rd_addr = 7;
      tick();
      wr_en = 0;
      chk("a_coll_old", ia.rd_data, 32'h0);
      chk("a_coll_v", 32'(ia.rd_valid), 32'd1);
      tick();
      rd_en = 0;
      chk("a_after_coll", ia.rd_data, 32'hCAFEF00D);
      chk("b_coll_new", ib.rd_data, 32'hCAFEF00D);
      tick(); tick();

      // out-of-range write/read (only dut_b is 12 deep)
      wr_en = 1; wr_addr = 13; wr_data = 32'hFFFFFFFF; wr_byte_en = 4'hF;
      tick();
      wr_en = 0; rd_en = 1; rd_addr = 14;
      tick();
      rd_en = 0;
      tick();
      chk("b_oor_data", ib.rd_data, 32'h0);
      chk("b_oor_valid", 32'(ib.rd_valid), 32'd1);
      for (int i = 0; i < 12; i++) begin
         rd_en = 1; rd_addr = 4'(i);
         tick();
      end
      idle();
      tick(); tick();

      // fill 16 words, then 16 back-to-back reads
      for (int i = 0; i < 16; i++) begin
         w[i] = $urandom;
         wr_en = 1; wr_addr = 4'(i); wr_data = w[i]; wr_byte_en = 4'hF;
         tick();
      end
      idle();
      cnt_v = 0; first_v = -1; last_v = -1; idx = 0;
      for (int n = 0; n < 20; n++) begin
         if (n < 16) begin
            rd_en = 1; rd_addr = 4'(n);
         end else begin
            rd_en = 0;
         end
         tick();
         if (ib.rd_valid) begin
            cnt_v++;
            if (first_v < 0) first_v = n;
            last_v = n;
            chk("b_burst_data", ib.rd_data, (idx < 12) ? w[idx] : 32'h0);
            idx++;
         end
      end
      chk("b_burst_cnt", 32'(cnt_v), 32'd16);
      chk("b_burst_first", 32'(first_v), 32'd1);
      chk("b_burst_span", 32'(last_v - first_v + 1), 32'd16);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         wr_en      = ($urandom_range(0, 3) != 0);
         wr_addr    = 4'($urandom_range(0, 15));
         wr_data    = $urandom;
         wr_byte_en = 4'($urandom_range(0, 15));
         rd_en      = ($urandom_range(0, 3) != 0);
         rd_addr    = ($urandom_range(0, 3) == 0) ? wr_addr
                                                  : 4'($urandom_range(0, 15));
         tick();
      end
      idle();
      tick(); tick();

      // reset in the middle of the clear restarts it
      do_reset(1);
      repeat (9) tick();
      rst_n = 0;
      model_reset();
      tick();
      rst_n = 1;
      na = 0; nb = 0;
      for (int n = 1; n <= 20; n++) begin
         tick();
         if (ia.init_done && na == 0) na = n;
         if (ib.init_done && nb == 0) nb = n;
      end
      chk("a_reclear_len", 32'(na), 32'd16);
      chk("b_reclear_len", 32'(nb), 32'd12);
      nz = 0;
      for (int n = 0; n < 18; n++) begin
         rd_en = (n < 16);
         rd_addr = 4'(n);
         tick();
         if (ia.rd_valid && ia.rd_data != 0) nz++;
         if (ib.rd_valid && ib.rd_data != 0) nz++;
      end
      chk("reclear_zero", 32'(nz), 32'd0);
      idle();
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
